display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Scan sequencer for the 8-digit multiplexed 7-segment display. It generates the 3-bit digit select that drives the 8:1 nibble mux feeding hex_to_7segment, plus the matching active-low anode enables. A per-slot blanking interval suppresses ghosting between digits. Per-digit enables support leading-zero or unused-digit suppression, and a frame strobe lets upstream logic update display data glitch-free.

Parameters:
TICK_DIV, 100000, clk cycles per digit slot (1 kHz slot rate at 100 MHz); legal range 2..2^20.
BLANK_CYC, 1000, cycles at the start of each slot with all anodes off; legal range 1..TICK_DIV-1.

Ports:
clk  input  1  system clock, rising-edge.
reset_n  input  1  asynchronous, active-low reset.
en  input  1  scan enable; 0 = display dark.
digit_en  input  8  per-digit enable; bit i gates digit i.
seg_sel  output  3  digit select for the nibble mux; 0 = rightmost digit.
anode  output  8  active-low anode enables; at most one bit is low at any time.
blank  output  1  1 = force segments off, for the segment driver.
frame_done  output  1  one-cycle pulse at the end of digit 7's slot.

Behaviour:
- State: FSM {IDLE, BLANK, DRIVE}, slot counter cnt[19:0], seg_sel register. All are reset asynchronously on reset_n=0.
- Reset values: state=IDLE, cnt=0, seg_sel=0, anode=8'hFF, blank=1, frame_done=0.
- Outputs are Moore-decoded from registered state:
  - anode = (state==DRIVE && digit_en[seg_sel]) ? ~(8'b1<<seg_sel) : 8'hFF.
  - blank = ~(state==DRIVE && digit_en[seg_sel]).
  - digit_en is not registered, so it takes effect in the same cycle it changes.
- IDLE: cnt=0, seg_sel=0. If en=1, go to BLANK next cycle.
- BLANK: cnt increments each cycle. When cnt==BLANK_CYC-1, go to DRIVE and increment cnt.
- DRIVE: cnt increments each cycle. When cnt==TICK_DIV-1:
  - cnt<=0, seg_sel<=seg_sel+1 (wraps 7->0), go to BLANK.
  - If seg_sel==7 at that edge, frame_done=1 for exactly the following cycle.
- Slot length is exactly TICK_DIV cycles: BLANK_CYC cycles blanked, then TICK_DIV-BLANK_CYC cycles driven. Frame length is 8*TICK_DIV cycles.
- Digits with digit_en=0 still consume their full slot; the scan rate is fixed.
- en=0 in any state: next cycle state=IDLE, cnt=0, seg_sel=0, and frame_done does not pulse. Re-enabling restarts from digit 0 in BLANK.
- Async reset mid-slot: outputs take reset values immediately, with no clk edge needed. Scanning resumes from IDLE after reset_n is released and en=1.
- Never more than one anode low. No anode is low in any cycle where seg_sel changes.

Test Plan (TICK_DIV=10, BLANK_CYC=2):
- Reset then en=1, digit_en=8'hFF:
  - IDLE for 1 cycle.
  - Digit 0: anode=8'hFF for 2 cycles, then 8'hFE for 8 cycles.
  - seg_sel then steps to 1 and anode=8'hFD after 2 blank cycles.
  - Same pattern continues for digits 2..7.
- Full frame: after 80 cycles in scan, frame_done pulses once for 1 cycle as seg_sel wraps 7->0. Pulse spacing is exactly 80 cycles over 3 frames.
- digit_en=8'b0000_0101: anode is low only during the DRIVE windows of digits 0 and 2, blank=1 at all other times, and frame period is still 80 cycles.
- en dropped at seg_sel=5, mid-DRIVE: next cycle anode=8'hFF, seg_sel=0, blank=1, and frame_done stays 0. Re-enabling restarts digit 0 with 2 blank cycles.
- reset_n asserted between clock edges during seg_sel=3 DRIVE: anode=8'hFF and seg_sel=0 immediately, without a clk edge.
- Assertion run over 10,000 cycles with random en/digit_en: popcount(~anode)<=1 always, and anode==8'hFF whenever seg_sel changes.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 8-digit 7-segment scan sequencer with per-slot blanking
module display_scan_ctrl #(
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [7:0] digit_en,
    output logic [2:0] seg_sel,
    output logic [7:0] anode,
    output logic       blank,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam logic [19:0] TICK_LAST  = 20'(TICK_DIV - 1);
    localparam logic [19:0] BLANK_LAST = 20'(BLANK_CYC - 1);

    state_t      state;
    state_t      state_nx;
    logic [19:0] cnt;
    logic        slot_end;
    logic        drive_on;

    // Last cycle of a slot: the driven window has used up the remaining cycles
    assign slot_end = (state == DRIVE) && (cnt == TICK_LAST);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; dropping en always returns to IDLE
    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    state_nx = BLANK;
                BLANK:   if (cnt == BLANK_LAST) state_nx = DRIVE;
                DRIVE:   if (slot_end) state_nx = BLANK;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Slot counter, digit select and end-of-frame pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            seg_sel    <= '0;
            frame_done <= 1'b0;
        end else if (!en) begin
            cnt        <= '0;
            seg_sel    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= slot_end && (seg_sel == 3'd7);
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    seg_sel <= '0;
                end
                BLANK: begin
                    cnt <= cnt + 20'd1;
                end
                DRIVE: begin
                    if (slot_end) begin
                        cnt     <= '0;
                        seg_sel <= seg_sel + 3'd1;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                default: begin
                    cnt     <= '0;
                    seg_sel <= '0;
                end
            endcase
        end
    end

    // Moore output decode; digit_en is used unregistered so it acts immediately
    always_comb begin
        drive_on = (state == DRIVE) && digit_en[seg_sel];
        anode    = drive_on ? ~(8'b1 << seg_sel) : 8'hFF;
        blank    = ~drive_on;
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - directed and random checks for display_scan_ctrl
module tb_display_scan_ctrl;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [7:0] digit_en;
    logic [2:0] seg_sel;
    logic [7:0] anode;
    logic       blank;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    display_scan_ctrl #(
        .TICK_DIV (10),
        .BLANK_CYC(2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .digit_en  (digit_en),
        .seg_sel   (seg_sel),
        .anode     (anode),
        .blank     (blank),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scan from digit 0 / BLANK; k=0 is the first cycle after the IDLE->BLANK edge
    task automatic run_scan(input int n, input logic [7:0] de, output int pulses);
        int         slot;
        int         pos;
        logic       drv;
        logic [7:0] exp_an;
        logic [7:0] one;
        pulses   = 0;
        digit_en = de;
        one      = 8'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            slot   = (k / 10) % 8;
            pos    = k % 10;
            drv    = (pos >= 2) && de[slot];
            exp_an = drv ? ~(one << slot) : 8'hFF;
            check($sformatf("anode k=%0d", k), 32'(anode), 32'(exp_an));
            check($sformatf("seg_sel k=%0d", k), 32'(seg_sel), 32'(slot % 8));
            check($sformatf("blank k=%0d", k), 32'(blank), 32'(!drv));
            check($sformatf("frame_done k=%0d", k), 32'(frame_done), 32'((k > 0) && (k % 80 == 0)));
            if (frame_done) pulses++;
        end
    endtask

    // Drop en for one cycle so the next scan starts cleanly from IDLE
    task automatic restart();
        en = 1'b0;
        @(negedge clk);
        check("restart anode", 32'(anode), 32'hFF);
        check("restart seg_sel", 32'(seg_sel), 32'd0);
        en = 1'b1;
    endtask

    initial begin
        int         pulses;
        logic [2:0] prev_sel;

        reset_n  = 1'b0;
        en       = 1'b0;
        digit_en = 8'hFF;
        #1;
        check("reset anode", 32'(anode), 32'hFF);
        check("reset seg_sel", 32'(seg_sel), 32'd0);
        check("reset blank", 32'(blank), 32'd1);
        check("reset frame_done", 32'(frame_done), 32'd0);

        // All digits, three frames
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        en      = 1'b1;
        check("idle anode", 32'(anode), 32'hFF);
        check("idle blank", 32'(blank), 32'd1);
        run_scan(241, 8'hFF, pulses);
        check("frame pulses x3", 32'(pulses), 32'd3);

        // Sparse digit enables
        restart();
        run_scan(161, 8'b0000_0101, pulses);
        check("sparse frame pulses", 32'(pulses), 32'd2);

        // en dropped mid-DRIVE of digit 5
        restart();
        run_scan(55, 8'hFF, pulses);
        en = 1'b0;
        @(negedge clk);
        check("en drop anode", 32'(anode), 32'hFF);
        check("en drop seg_sel", 32'(seg_sel), 32'd0);
        check("en drop blank", 32'(blank), 32'd1);
        check("en drop frame_done", 32'(frame_done), 32'd0);
        en = 1'b1;
        run_scan(12, 8'hFF, pulses);

        // en dropped on the last cycle of digit 7: no frame pulse
        restart();
        run_scan(80, 8'hFF, pulses);
        en = 1'b0;
        @(negedge clk);
        check("en drop at wrap frame_done", 32'(frame_done), 32'd0);
        check("en drop at wrap seg_sel", 32'(seg_sel), 32'd0);
        en = 1'b1;
        run_scan(12, 8'hFF, pulses);

        // Asynchronous reset during digit 3 DRIVE
        restart();
        run_scan(35, 8'hFF, pulses);
        check("pre-reset anode", 32'(anode), 32'hF7);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset anode", 32'(anode), 32'hFF);
        check("async reset seg_sel", 32'(seg_sel), 32'd0);
        check("async reset blank", 32'(blank), 32'd1);
        check("async reset frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        check("post-reset idle anode", 32'(anode), 32'hFF);
        run_scan(20, 8'hFF, pulses);

        // Random en / digit_en: anode invariants
        prev_sel = seg_sel;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            check("one anode low", 32'($countones(~anode) <= 1), 32'd1);
            if (seg_sel != prev_sel) check("anode off on seg_sel change", 32'(anode), 32'hFF);
            prev_sel = seg_sel;
            en       = ($urandom_range(0, 63) != 0);
            digit_en = 8'($urandom);
            #1;
            check("one anode low after input change", 32'($countones(~anode) <= 1), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
